// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, RGB565 packing and writer state encoding
// Contents: FB_WIDTH/FB_HEIGHT/FB_WORDS geometry, pack_rgb565() colour packer,
//           wr_state_t state enum used by fragment_writer.

package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 400;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

    // Keep the top bits of each 16-bit channel: 5 red, 6 green, 5 blue.
    function automatic logic [15:0] pack_rgb565(input logic [4:0] r5,
                                                input logic [5:0] g6,
                                                input logic [4:0] b5);
        return {r5, g6, b5};
    endfunction

endpackage

// File: rtl/frag_fifo.sv
// rtl/frag_fifo.sv - synchronous fragment FIFO with registered full flag and occupancy count
// Ports:
//   clk        in   clock, state changes on the falling edge
//   rst        in   asynchronous active-high reset
//   push       in   write push_data (ignored while full)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored while empty)
//   head       out  oldest entry
//   full       out  registered, high while count == DEPTH
//   empty      out  high while count == 0
//   count      out  occupancy, $clog2(DEPTH)+1 bits

module frag_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count != '0);

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + (AW + 1)'(1);
            2'b01:   count_next = count - (AW + 1)'(1);
            default: count_next = count;
        endcase
    end

    // Full is registered from the next count so it rises in the same cycle the
    // count reaches DEPTH; a one-cycle lag here would let an extra push slip in.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_next;
            full_q <= (count_next == DEPTH_C);
        end
    end

    always_ff @(negedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = full_q;
    assign empty = (count == '0);

endmodule

// File: rtl/fragment_writer.sv
// rtl/fragment_writer.sv - buffers shaded fragments and writes them, or a clear fill, to the SRAM framebuffer
// Ports:
//   I_CLOCK, I_RESET            clock (falling-edge state changes), async active-high reset
//   I_FragValid/Addr/Color      incoming fragment; colour packed to RGB565 on push
//   I_FrameStall                rasterizer busy; falling edge marks end of traversal
//   I_ClearReq, I_ClearColor    framebuffer clear request and fill value
//   I_SramReady                 write port granted this cycle
//   O_Full                      FIFO full, upstream must hold
//   O_SramWE/Addr/Data          registered write strobe, address, data
//   O_FrameDone                 one-cycle frame completion pulse
//   O_Busy                      draining, clearing or holding fragments

module fragment_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_WORDS   = fb_pkg::FB_WORDS
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic        I_FragValid,
    input  logic [17:0] I_FragAddr,
    input  logic [63:0] I_FragColor,
    input  logic        I_FrameStall,
    input  logic        I_ClearReq,
    input  logic [15:0] I_ClearColor,
    input  logic        I_SramReady,
    output logic        O_Full,
    output logic        O_SramWE,
    output logic [17:0] O_SramAddr,
    output logic [15:0] O_SramData,
    output logic        O_FrameDone,
    output logic        O_Busy
);

    import fb_pkg::*;

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [17:0] LAST_ADDR = 18'(FB_WORDS - 1);

    wr_state_t   state_q, state_d;
    logic [17:0] clear_addr_q;
    logic [15:0] clear_color_q;
    logic        clear_pending_q;
    logic        pending_done_q;
    logic        stall_q;
    logic        ovf_seen;
    logic        we_q;
    logic [17:0] addr_q;
    logic [15:0] data_q;

    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [33:0] fifo_head;
    logic        push, pop;
    logic        clear_write, clear_last, clear_accept, drain_done;
    logic        unused_sink;

    // Upper colour bits carry no information; ovf_seen is a debug bit read hierarchically.
    assign unused_sink = ^{I_FragColor[63:48], ovf_seen};

    assign push         = I_FragValid && !fifo_full && (I_FragAddr <= LAST_ADDR);
    assign pop          = (state_q == ST_DRAIN) && I_SramReady && !fifo_empty;
    assign clear_write  = (state_q == ST_CLEAR) && I_SramReady;
    assign clear_last   = clear_write && (clear_addr_q == LAST_ADDR);
    assign clear_accept = I_ClearReq && (state_q != ST_CLEAR);
    // Leave DRAIN on the same edge as the final pop so the done pulse can
    // follow the last write by exactly one cycle.
    assign drain_done   = fifo_empty || (pop && !push && fifo_count == CW'(1));

    frag_fifo #(
        .WIDTH (34),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (I_CLOCK),
        .rst       (I_RESET),
        .push      (push),
        .push_data ({I_FragAddr, pack_rgb565(I_FragColor[15:11], I_FragColor[31:26], I_FragColor[47:43])}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty)                        state_d = ST_DRAIN;
                else if (I_ClearReq || clear_pending_q) state_d = ST_CLEAR;
                else if (pending_done_q)                state_d = ST_DONE;
            end
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            ST_CLEAR: if (clear_last) state_d = ST_IDLE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q         <= ST_IDLE;
            clear_addr_q    <= '0;
            clear_color_q   <= '0;
            clear_pending_q <= 1'b0;
            pending_done_q  <= 1'b0;
            stall_q         <= 1'b0;
            ovf_seen        <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= I_FrameStall;

            if (stall_q && !I_FrameStall)                    pending_done_q <= 1'b1;
            else if (state_q == ST_IDLE && state_d == ST_DONE) pending_done_q <= 1'b0;

            // A request that cannot start immediately waits for the FIFO to empty.
            if (state_q != ST_CLEAR && state_d == ST_CLEAR) clear_pending_q <= 1'b0;
            else if (clear_accept)                          clear_pending_q <= 1'b1;

            if (clear_accept) clear_color_q <= I_ClearColor;

            if (clear_last)       clear_addr_q <= '0;
            else if (clear_write) clear_addr_q <= clear_addr_q + 18'd1;

            if (I_FragValid && fifo_full) ovf_seen <= 1'b1;

            we_q <= pop || clear_write;
            if (pop) begin
                addr_q <= fifo_head[33:16];
                data_q <= fifo_head[15:0];
            end else if (clear_write) begin
                addr_q <= clear_addr_q;
                data_q <= clear_color_q;
            end
        end
    end

    assign O_Full      = fifo_full;
    assign O_SramWE    = we_q;
    assign O_SramAddr  = addr_q;
    assign O_SramData  = data_q;
    assign O_FrameDone = (state_q == ST_DONE);
    assign O_Busy      = (state_q == ST_DRAIN) || (state_q == ST_CLEAR) || !fifo_empty;

endmodule
